dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer that sits directly upstream of the `dds` sine generator and drives its `fre_w` and `pha_w` inputs. It steps the excitation through `n_points` linearly spaced tuning words. At each point it waits a settle interval, then asserts a measurement window so the downstream ADC/demodulation path can integrate at that frequency. This makes a complete impedance-spectroscopy sweep a single `start` pulse.

## Interface
- `FWORD_WIDTH`, 28, tuning-word width; must equal the `dds` frequency-word width.
- `PWORD_WIDTH`, 10, phase-word width; must equal the `dds` phase-word width.
- `POINT_WIDTH`, 8, width of the point count and point index.
- `TIME_WIDTH`, 24, width of the settle and dwell cycle counts.
- `clk` in 1: system clock, the same clock as `dds`.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: terminates the sweep; has priority over `start`.
- `f_start` in FWORD_WIDTH: first tuning word.
- `f_step` in FWORD_WIDTH: increment between points (unsigned).
- `n_points` in POINT_WIDTH: number of points.
- `settle` in TIME_WIDTH: settle cycles per point.
- `dwell` in TIME_WIDTH: measurement cycles per point.
- `pha_offset` in PWORD_WIDTH: phase word for the sweep.
- `fre_w` out FWORD_WIDTH: tuning word to `dds`.
- `pha_w` out PWORD_WIDTH: phase word to `dds`.
- `point_idx` out POINT_WIDTH: current point, 0-based.
- `meas_valid` out 1: high during the measurement window.
- `point_done` out 1: one-cycle pulse on the last `meas_valid` cycle of each point.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a completed sweep.

## Operation
- **States:** IDLE, SETTLE, MEASURE, DONE.
- **Reset:** `rst` forces the state to IDLE and drives every output to 0, including `fre_w` and `pha_w`. Reset applied mid-sweep does the same; no `done` pulse is produced.
- **IDLE, `start`=1 and `n_points`≠0:**
  - latch `f_step`, `n_points`, `settle`, `dwell` into shadow registers; input changes after this edge have no effect on the sweep in progress;
  - `fre_w` ← `f_start`, `pha_w` ← `pha_offset`, `point_idx` ← 0;
  - move to SETTLE.
- **IDLE, `start`=1 and `n_points`=0:** move to DONE. No other register changes.
- **SETTLE:** lasts max(`settle`,1) cycles, then MEASURE.
- **MEASURE:** lasts max(`dwell`,1) cycles. `meas_valid`=1 throughout. `point_done`=1 on the final cycle. At the end of that cycle:
  - if `point_idx` = `n_points`−1, move to DONE;
  - otherwise `fre_w` ← `fre_w`+`f_step` (wraps modulo 2^FWORD_WIDTH, no saturation), `point_idx` ← `point_idx`+1, move to SETTLE.
- **DONE:** one cycle with `done`=1, then IDLE.
- **After completion:** `fre_w`, `pha_w` and `point_idx` hold their final values until the next `start`.
- **`abort`=1 in any non-IDLE state:** next state is IDLE, `fre_w` ← 0, `meas_valid`/`point_done`/`done` stay 0. An abort in the DONE cycle suppresses nothing, because `done` is already asserted in that cycle.
- **`abort` in IDLE:** no effect.
- **`start` outside IDLE:** ignored.
- **`start` and `abort` both high in IDLE:** `abort` wins, so `start` is ignored.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled on edge k gives `busy`=1 and `fre_w`=`f_start` from cycle k+1.
- Per-point period is max(`settle`,1) + max(`dwell`,1) cycles.
- `fre_w` changes only on the cycle in which SETTLE is entered.
- `dds` adds a 3-cycle pipeline (register, accumulator, ROM) after `fre_w` changes. Software must program `settle` ≥ 3 plus the analog settling time. This is not enforced in hardware.
- `busy` falls on the cycle after `done`.

## Structure
- **Package `dds_sweep_pkg`:** state enum (IDLE, SETTLE, MEASURE, DONE) and default width constants shared with `dds`.
- **Sub-module `sweep_timer`:**
  - loadable down-counter of width TIME_WIDTH;
  - load value max(n,1);
  - outputs `expire` on the final count;
  - reused for both the SETTLE and MEASURE intervals.
- **The FSM, shadow registers and tuning-word adder stay in the top module.**

## Test plan
- **Basic sweep:** `f_start`=0x0100000, `f_step`=0x0010000, `n_points`=3, `settle`=4, `dwell`=8, `start` at cycle 0 →
  - `fre_w` is 0x0100000 for cycles 1–12, 0x0110000 for cycles 13–24, 0x0120000 for cycles 25–36;
  - `meas_valid` high in cycles 5–12, 17–24 and 29–36;
  - `point_done` at cycles 12, 24 and 36;
  - `done` at 37, `busy` low at 38.
- **Zero points:** `n_points`=0 → `done` at cycle 1, `meas_valid` never asserts, `fre_w` unchanged.
- **Wrap:** `f_start`=0xFFFFFF0, `f_step`=0x20, `n_points`=2 → second-point `fre_w` = 0x0000010.
- **Abort:** `abort` at cycle 15 of the basic sweep → IDLE at 16, `fre_w`=0, no `done`. A `start` issued while busy is ignored.
- **Reset mid-MEASURE:** every output is 0 on the next cycle. A new `start` then replays the basic sweep exactly.
- **Minimum intervals:** `settle`=0, `dwell`=0, `n_points`=2 → each point lasts 2 cycles, `meas_valid` is high 1 cycle per point, `done` at cycle 5.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep sequencer: FSM state encoding
// and the default word widths that must match the downstream dds core.
package dds_sweep_pkg;

   localparam int FWORD_WIDTH_DEF = 28;
   localparam int PWORD_WIDTH_DEF = 10;
   localparam int POINT_WIDTH_DEF = 8;
   localparam int TIME_WIDTH_DEF  = 24;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl_timer.sv
// Loadable down-counter timing both the settle and the measurement interval of
// a sweep point. A load of 0 is treated as 1 so every interval lasts a cycle.
module sweep_timer #(
   parameter int TIME_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [TIME_WIDTH-1:0] load_val_i,
   output logic                  expire_o,
   output logic                  near_o
);

   logic [TIME_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (load_val_i == '0) ? TIME_WIDTH'(1) : load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TIME_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // expire marks the final cycle of the interval; near the cycle before it
   assign expire_o = (cnt_q == TIME_WIDTH'(1));
   assign near_o   = (cnt_q == TIME_WIDTH'(2));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the dds tuning and phase words: steps through
// n_points linear frequencies, settling then opening a measurement window at each.
module dds_sweep_ctrl
   import dds_sweep_pkg::*;
#(
   parameter int FWORD_WIDTH = FWORD_WIDTH_DEF,
   parameter int PWORD_WIDTH = PWORD_WIDTH_DEF,
   parameter int POINT_WIDTH = POINT_WIDTH_DEF,
   parameter int TIME_WIDTH  = TIME_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [FWORD_WIDTH-1:0] f_start,
   input  logic [FWORD_WIDTH-1:0] f_step,
   input  logic [POINT_WIDTH-1:0] n_points,
   input  logic [TIME_WIDTH-1:0]  settle,
   input  logic [TIME_WIDTH-1:0]  dwell,
   input  logic [PWORD_WIDTH-1:0] pha_offset,
   output logic [FWORD_WIDTH-1:0] fre_w,
   output logic [PWORD_WIDTH-1:0] pha_w,
   output logic [POINT_WIDTH-1:0] point_idx,
   output logic                   meas_valid,
   output logic                   point_done,
   output logic                   busy,
   output logic                   done
);

   sweep_state_e           state_q;
   logic [FWORD_WIDTH-1:0] fre_q, step_q;
   logic [PWORD_WIDTH-1:0] pha_q;
   logic [POINT_WIDTH-1:0] idx_q, n_q;
   logic [TIME_WIDTH-1:0]  settle_q, dwell_q;
   logic                   meas_q, pdone_q, busy_q, done_q;

   logic                   tmr_load;
   logic [TIME_WIDTH-1:0]  tmr_val;
   logic                   tmr_expire, tmr_near;
   logic                   last_point;
   logic                   start_ok;

   assign last_point = (idx_q == n_q - POINT_WIDTH'(1));
   assign start_ok   = start && !abort && (n_points != '0);

   // Timer reloads on every interval boundary; IDLE uses the live settle input
   // because the shadow register is only written on that same edge.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = settle_q;
      case (state_q)
         ST_IDLE: begin
            tmr_load = start_ok;
            tmr_val  = settle;
         end
         ST_SETTLE: begin
            tmr_load = !abort && tmr_expire;
            tmr_val  = dwell_q;
         end
         ST_MEASURE: tmr_load = !abort && tmr_expire && !last_point;
         default:    tmr_load = 1'b0;
      endcase
   end

   sweep_timer #(.TIME_WIDTH(TIME_WIDTH)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire),
      .near_o     (tmr_near)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         fre_q    <= '0;
         pha_q    <= '0;
         idx_q    <= '0;
         step_q   <= '0;
         n_q      <= '0;
         settle_q <= '0;
         dwell_q  <= '0;
         meas_q   <= 1'b0;
         pdone_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (abort && state_q != ST_IDLE) begin
         state_q <= ST_IDLE;
         fre_q   <= '0;
         meas_q  <= 1'b0;
         pdone_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  busy_q <= 1'b1;
                  if (n_points != '0) begin
                     step_q   <= f_step;
                     n_q      <= n_points;
                     settle_q <= settle;
                     dwell_q  <= dwell;
                     fre_q    <= f_start;
                     pha_q    <= pha_offset;
                     idx_q    <= '0;
                     state_q  <= ST_SETTLE;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_SETTLE: begin
               if (tmr_expire) begin
                  state_q <= ST_MEASURE;
                  meas_q  <= 1'b1;
                  pdone_q <= (dwell_q <= TIME_WIDTH'(1));
               end
            end
            ST_MEASURE: begin
               if (tmr_expire) begin
                  meas_q  <= 1'b0;
                  pdone_q <= 1'b0;
                  if (last_point) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     fre_q   <= fre_q + step_q;
                     idx_q   <= idx_q + POINT_WIDTH'(1);
                     state_q <= ST_SETTLE;
                  end
               end else begin
                  pdone_q <= tmr_near;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fre_w      = fre_q;
   assign pha_w      = pha_q;
   assign point_idx  = idx_q;
   assign meas_valid = meas_q;
   assign point_done = pdone_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: per-cycle expectation tables built from the
// sweep timeline, plus hand-written reset, zero-point and IDLE-abort sequences.
module tb_dds_sweep_ctrl;

   localparam int FW = 28;
   localparam int PW = 10;
   localparam int NW = 8;
   localparam int TW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort;
   logic [FW-1:0] f_start, f_step;
   logic [NW-1:0] n_points;
   logic [TW-1:0] settle, dwell;
   logic [PW-1:0] pha_offset;
   logic [FW-1:0] fre_w;
   logic [PW-1:0] pha_w;
   logic [NW-1:0] point_idx;
   logic          meas_valid, point_done, busy, done;

   always #5 clk = ~clk;

   dds_sweep_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .f_start    (f_start),
      .f_step     (f_step),
      .n_points   (n_points),
      .settle     (settle),
      .dwell      (dwell),
      .pha_offset (pha_offset),
      .fre_w      (fre_w),
      .pha_w      (pha_w),
      .point_idx  (point_idx),
      .meas_valid (meas_valid),
      .point_done (point_done),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic          start;
      logic          abort;
      logic          chk;
      logic [FW-1:0] fre;
      logic [PW-1:0] pha;
      logic [NW-1:0] idx;
      logic          mv;
      logic          pd;
      logic          busy;
      logic          done;
   } vec_t;

   vec_t vecs[64];
   int   checks = 0;
   int   errors = 0;

   logic [FW-1:0] cfg_fs, cfg_step;
   logic [NW-1:0] cfg_n;
   logic [TW-1:0] cfg_s, cfg_d;
   logic [PW-1:0] cfg_pha;

   task automatic check(input string name, input int c, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
      end
   endtask

   task automatic check_outs(input int c, input vec_t v);
      check("fre_w",      c, 32'(fre_w),      32'(v.fre));
      check("pha_w",      c, 32'(pha_w),      32'(v.pha));
      check("point_idx",  c, 32'(point_idx),  32'(v.idx));
      check("meas_valid", c, 32'(meas_valid), 32'(v.mv));
      check("point_done", c, 32'(point_done), 32'(v.pd));
      check("busy",       c, 32'(busy),       32'(v.busy));
      check("done",       c, 32'(done),       32'(v.done));
   endtask

   // Timeline: point p spans cycles 1+p*P .. (p+1)*P; its last max(dwell,1)
   // cycles are the measurement window; done follows the final point.
   task automatic fill(input int ncyc, input int abort_cyc);
      int s_len, d_len, per, last_c, p, off;
      s_len  = (cfg_s == '0) ? 1 : int'(cfg_s);
      d_len  = (cfg_d == '0) ? 1 : int'(cfg_d);
      per    = s_len + d_len;
      last_c = int'(cfg_n) * per;
      for (int c = 0; c < ncyc; c++) begin
         vecs[c] = '{default: '0};
         vecs[c].start = (c == 0) || (c == 8 && last_c >= 8);
         vecs[c].abort = (c == abort_cyc);
         vecs[c].chk   = (c != 0);
         if (c == 0) begin
            vecs[c].chk = 1'b0;
         end else if (c <= last_c) begin
            p   = (c - 1) / per;
            off = (c - 1) % per;
            vecs[c].fre  = cfg_fs + cfg_step * FW'(p);
            vecs[c].idx  = NW'(p);
            vecs[c].pha  = cfg_pha;
            vecs[c].mv   = (off >= s_len);
            vecs[c].pd   = (off == per - 1);
            vecs[c].busy = 1'b1;
         end else begin
            vecs[c].fre  = cfg_fs + cfg_step * FW'(cfg_n - NW'(1));
            vecs[c].idx  = cfg_n - NW'(1);
            vecs[c].pha  = cfg_pha;
            vecs[c].done = (c == last_c + 1);
            vecs[c].busy = vecs[c].done;
         end
         if (abort_cyc > 0 && c > abort_cyc) begin
            vecs[c].fre  = '0;
            vecs[c].idx  = vecs[abort_cyc].idx;
            vecs[c].mv   = 1'b0;
            vecs[c].pd   = 1'b0;
            vecs[c].busy = 1'b0;
            vecs[c].done = 1'b0;
         end
      end
   endtask

   // Cycle c is sampled at the falling edge before rising edge c; inputs set
   // here are taken on that rising edge. Config is scrambled after the start.
   task automatic run_table(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (vecs[c].chk) check_outs(c, vecs[c]);
         start = vecs[c].start;
         abort = vecs[c].abort;
         if (c == 0) begin
            f_start    = cfg_fs;
            f_step     = cfg_step;
            n_points   = cfg_n;
            settle     = cfg_s;
            dwell      = cfg_d;
            pha_offset = cfg_pha;
         end else if (c == 2) begin
            f_start    = ~cfg_fs;
            f_step     = cfg_step + FW'(3);
            n_points   = cfg_n + NW'(1);
            settle     = cfg_s + TW'(5);
            dwell      = cfg_d + TW'(2);
            pha_offset = ~cfg_pha;
         end
      end
   endtask

   task automatic set_basic();
      cfg_fs   = 28'h0100000;
      cfg_step = 28'h0010000;
      cfg_n    = 8'd3;
      cfg_s    = 24'd4;
      cfg_d    = 24'd8;
      cfg_pha  = 10'h155;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fre_w"},      0, 32'(fre_w),      32'h0);
      check({tag, "_pha_w"},      0, 32'(pha_w),      32'h0);
      check({tag, "_point_idx"},  0, 32'(point_idx),  32'h0);
      check({tag, "_meas_valid"}, 0, 32'(meas_valid), 32'h0);
      check({tag, "_point_done"}, 0, 32'(point_done), 32'h0);
      check({tag, "_busy"},       0, 32'(busy),       32'h0);
      check({tag, "_done"},       0, 32'(done),       32'h0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      f_start = '0; f_step = '0; n_points = '0;
      settle = '0; dwell = '0; pha_offset = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // Basic sweep, with a start at cycle 8 that must be ignored
      set_basic();
      fill(40, -1);
      run_table(40);

      // Zero points: immediate done, sweep registers untouched
      @(negedge clk);
      n_points = 8'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_done",  1, 32'(done),       32'h1);
      check("zero_busy",  1, 32'(busy),       32'h1);
      check("zero_meas",  1, 32'(meas_valid), 32'h0);
      check("zero_fre_w", 1, 32'(fre_w),      32'h0120000);
      check("zero_idx",   1, 32'(point_idx),  32'h2);
      @(negedge clk);
      check("zero_done_end", 2, 32'(done),  32'h0);
      check("zero_busy_end", 2, 32'(busy),  32'h0);
      check("zero_fre_end",  2, 32'(fre_w), 32'h0120000);

      // start and abort together in IDLE: abort wins, nothing happens
      n_points = 8'd3;
      start    = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_busy",  1, 32'(busy),  32'h0);
      check("idle_abort_fre_w", 1, 32'(fre_w), 32'h0120000);
      check("idle_abort_done",  1, 32'(done),  32'h0);

      // Abort at cycle 15 of the basic sweep
      set_basic();
      fill(40, 15);
      run_table(40);

      // Reset mid-MEASURE, then replay the basic sweep
      set_basic();
      fill(40, -1);
      run_table(8);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      rst = 1'b0;
      run_table(40);

      // Minimum intervals, then the same with abort in the DONE cycle
      cfg_fs   = 28'h0200000;
      cfg_step = 28'h0001000;
      cfg_n    = 8'd2;
      cfg_s    = 24'd0;
      cfg_d    = 24'd0;
      cfg_pha  = 10'h2AA;
      fill(8, -1);
      run_table(8);
      fill(8, 5);
      run_table(8);

      // Tuning word wraps modulo 2^28 on the second point
      cfg_fs   = 28'hFFFFFF0;
      cfg_step = 28'h0000020;
      cfg_n    = 8'd2;
      cfg_s    = 24'd3;
      cfg_d    = 24'd2;
      cfg_pha  = 10'h001;
      fill(14, -1);
      run_table(14);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
